// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, field widths and defaults for the game round controller
package game_pkg;

  // FSM state encoding, also exported on state_dbg for the LEDs
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_OVER   = 3'd4
  } game_state_t;

  localparam int LIVES_W             = 2;
  localparam int LEVEL_W             = 3;
  localparam int PAUSE_W             = 8;
  localparam int WIN_W               = 8;
  localparam int PAUSE_TICKS_DEFAULT = 100;
  localparam int SCORE_DIGITS_DEFAULT = 4;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_sat_adder.sv
// rtl/bcd_sat_adder.sv - adds a small binary increment to a multi-digit BCD number, saturating at all nines
//
// Ports:
//   addend_bcd  in   DIGITS*4  BCD operand, digit 0 in [3:0]
//   increment   in   4         binary increment, 0..8
//   sum_bcd     out  DIGITS*4  BCD sum, forced to all nines on overflow
module bcd_sat_adder
  import game_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] addend_bcd,
  input  logic [3:0]          increment,
  output logic [4*DIGITS-1:0] sum_bcd
);

  logic [4*DIGITS-1:0] raw_sum;
  logic                carry;
  logic [4:0]          digit_in;
  logic [4:0]          digit_total;
  logic [4:0]          digit_wrapped;
  bcd_digit_t          digit_val;

  // Ripple from digit 0 upward; only digit 0 sees the increment, the rest
  // see just the carry. With an increment of at most 8 a digit total never
  // exceeds 17, so a single subtract-10 correction is enough.
  always_comb begin
    raw_sum       = '0;
    carry         = 1'b0;
    digit_in      = 5'd0;
    digit_total   = 5'd0;
    digit_wrapped = 5'd0;
    digit_val     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_val   = addend_bcd[4*i +: 4];
      digit_in    = (i == 0) ? {1'b0, increment} : 5'd0;
      digit_total = {1'b0, digit_val} + digit_in + {4'd0, carry};
      if (digit_total > 5'd9) begin
        digit_wrapped      = digit_total - 5'd10;
        raw_sum[4*i +: 4]  = digit_wrapped[3:0];
        carry              = 1'b1;
      end else begin
        raw_sum[4*i +: 4]  = digit_total[3:0];
        carry              = 1'b0;
      end
    end
    sum_bcd = carry ? {DIGITS{4'h9}} : raw_sum;
  end

endmodule

// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - sequences rounds of the aim-and-shoot game, tracking lives, level and BCD score
//
// Ports:
//   clock        in   1                system clock
//   reset        in   1                synchronous, active-high
//   tick         in   1                one-cycle game-rate strobe
//   start_btn    in   1                level-sensitive start request
//   round_won    in   1                core pulse: target hit
//   round_lost   in   1                core pulse: projectile left screen
//   round_start  out  1                one-cycle pulse restarting the core's round
//   playing      out  1                high while a round is in progress
//   game_over    out  1                high once all lives are spent
//   level        out  3                current level, 0-based
//   lives        out  2                remaining lives
//   score        out  4*SCORE_DIGITS   BCD score, digit 0 in [3:0]
//   state_dbg    out  3                FSM state encoding
module game_round_controller
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int MAX_LEVEL      = 7,
  parameter int WINS_PER_LEVEL = 3,
  parameter int PAUSE_TICKS    = PAUSE_TICKS_DEFAULT,
  parameter int SCORE_DIGITS   = SCORE_DIGITS_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      start_btn,
  input  logic                      round_won,
  input  logic                      round_lost,
  output logic                      round_start,
  output logic                      playing,
  output logic                      game_over,
  output logic [LEVEL_W-1:0]        level,
  output logic [LIVES_W-1:0]        lives,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [2:0]                state_dbg
);

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_TICKS);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINS_PER_LEVEL - 1);

  game_state_t               state;
  logic [PAUSE_W-1:0]        pause_cnt;
  logic [WIN_W-1:0]          win_cnt;
  logic                      start_prev;
  logic [3:0]                score_inc;
  logic [4*SCORE_DIGITS-1:0] score_next;

  // A win is worth level+1 points; the adder is purely combinational so the
  // new score lands in the register on the same edge that leaves PLAY.
  assign score_inc = {1'b0, level} + 4'd1;

  bcd_sat_adder #(
    .DIGITS (SCORE_DIGITS)
  ) u_score_adder (
    .addend_bcd (score),
    .increment  (score_inc),
    .sum_bcd    (score_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      level      <= '0;
      lives      <= LIVES_LOAD;
      score      <= '0;
      win_cnt    <= '0;
      pause_cnt  <= '0;
      start_prev <= 1'b0;
    end else begin
      // Previous button level, used only to find a fresh press in OVER so a
      // button still held from the last round cannot restart the game.
      start_prev <= start_btn;

      case (state)
        ST_IDLE: begin
          if (start_btn) begin
            state   <= ST_LAUNCH;
            lives   <= LIVES_LOAD;
            level   <= '0;
            score   <= '0;
            win_cnt <= '0;
          end
        end

        ST_LAUNCH: begin
          state <= ST_PLAY;
        end

        ST_PLAY: begin
          // A loss outranks a simultaneous win; tick has no effect here.
          if (round_lost) begin
            lives <= lives - 1'b1;
            if (lives == LIVES_W'(1)) begin
              state <= ST_OVER;
            end else begin
              state     <= ST_PAUSE;
              pause_cnt <= PAUSE_LOAD;
            end
          end else if (round_won) begin
            score     <= score_next;
            state     <= ST_PAUSE;
            pause_cnt <= PAUSE_LOAD;
            if (win_cnt == WIN_LAST) begin
              // Counter clears even when the level is already at its ceiling.
              win_cnt <= '0;
              if (level < LEVEL_MAX) begin
                level <= level + 1'b1;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end

        ST_PAUSE: begin
          // Counter starts at PAUSE_TICKS and the exit needs one more tick
          // once it reaches zero, giving PAUSE_TICKS+1 ticks in total.
          if (tick) begin
            if (pause_cnt == '0) begin
              state <= ST_LAUNCH;
            end else begin
              pause_cnt <= pause_cnt - 1'b1;
            end
          end
        end

        ST_OVER: begin
          if (start_btn && !start_prev) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All status outputs decode straight from the state register, so a reset
  // clears them on the very next edge and LAUNCH yields exactly one pulse.
  assign round_start = (state == ST_LAUNCH);
  assign playing     = (state == ST_PLAY);
  assign game_over   = (state == ST_OVER);
  assign state_dbg   = state;

endmodule

// File: tb/tb_game_round_controller.sv
// tb/tb_game_round_controller.sv - directed scoreboard bench for game_round_controller
module tb_game_round_controller;
  import game_pkg::*;

  localparam int P      = 4;
  localparam int WPL    = 3;
  localparam int MAXL   = 7;
  localparam int LIVES0 = 3;
  localparam int DIG    = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            tick;
  logic            start_btn;
  logic            round_won;
  logic            round_lost;
  logic            round_start;
  logic            playing;
  logic            game_over;
  logic [2:0]      level;
  logic [1:0]      lives;
  logic [4*DIG-1:0] score;
  logic [2:0]      state_dbg;

  game_round_controller #(
    .LIVES_INIT     (LIVES0),
    .MAX_LEVEL      (MAXL),
    .WINS_PER_LEVEL (WPL),
    .PAUSE_TICKS    (P),
    .SCORE_DIGITS   (DIG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .start_btn   (start_btn),
    .round_won   (round_won),
    .round_lost  (round_lost),
    .round_start (round_start),
    .playing     (playing),
    .game_over   (game_over),
    .level       (level),
    .lives       (lives),
    .score       (score),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          state;
    int          lives;
    int          level;
    logic [15:0] score;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit tick_en  = 1'b1;
  int pause_ticks = 0;
  int pulses   = 0;
  int m_score, m_level, m_lives, m_wins;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive the tick for the coming edge, note ticks the DUT will
  // consume while in PAUSE, then advance to the next falling edge.
  task automatic cycle();
    tick = tick_en && (cyc % 2 == 0);
    if (tick && state_dbg == ST_PAUSE) pause_ticks++;
    @(negedge clock);
    cyc++;
  endtask

  task automatic check_reset_state();
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_round_start", round_start, 0);
    chk("rst_playing", playing, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_level", level, 0);
    chk("rst_lives", lives, LIVES0);
    chk("rst_score", score, 0);
  endtask

  task automatic model_reset();
    m_score = 0;
    m_level = 0;
    m_lives = LIVES0;
    m_wins  = 0;
  endtask

  task automatic play_event(input bit won, input bit lost);
    exp_t e;
    if (lost) begin
      m_lives--;
      e.state = (m_lives == 0) ? ST_OVER : ST_PAUSE;
    end else begin
      m_score = (m_score + m_level + 1 > 9999) ? 9999 : m_score + m_level + 1;
      m_wins++;
      if (m_wins == WPL) begin
        m_wins = 0;
        if (m_level < MAXL) m_level++;
      end
      e.state = ST_PAUSE;
    end
    e.lives = m_lives;
    e.level = m_level;
    e.score = to_bcd(m_score);
    sb.push_back(e);
    pause_ticks = 0;
    round_won  = won;
    round_lost = lost;
    cycle();
    round_won  = 1'b0;
    round_lost = 1'b0;
    e = sb.pop_front();
    chk("ev_state", state_dbg, e.state);
    chk("ev_lives", lives, e.lives);
    chk("ev_level", level, e.level);
    chk("ev_score", score, e.score);
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    while (round_start !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    chk("launch_seen", round_start, 1);
    chk("pause_ticks", pause_ticks, P + 1);
    cycle();
    chk("pulse_one_clk", round_start, 0);
    chk("play_again", playing, 1);
  endtask

  initial begin
    reset      = 1'b1;
    tick       = 1'b0;
    start_btn  = 1'b0;
    round_won  = 1'b0;
    round_lost = 1'b0;
    repeat (3) cycle();
    check_reset_state();
    reset = 1'b0;
    cycle();
    chk("idle_wait", state_dbg, ST_IDLE);

    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    chk("launch_state", state_dbg, ST_LAUNCH);
    chk("launch_pulse", round_start, 1);
    cycle();
    chk("launch_one_clk", round_start, 0);
    chk("play1", playing, 1);
    chk("play1_lives", lives, 3);
    chk("play1_level", level, 0);
    chk("play1_score", score, 16'h0000);
    model_reset();

    play_event(1'b1, 1'b0);
    chk("win1_score", score, 16'h0001);
    round_won = 1'b1;
    cycle();
    round_won = 1'b0;
    chk("pause_ignore_score", score, 16'h0001);
    chk("pause_ignore_state", state_dbg, ST_PAUSE);
    wait_launch();
    play_event(1'b1, 1'b0);
    wait_launch();
    play_event(1'b1, 1'b0);
    chk("lvl1", level, 1);
    chk("score3", score, 16'h0003);
    wait_launch();
    play_event(1'b1, 1'b0);
    chk("score5", score, 16'h0005);
    wait_launch();

    play_event(1'b1, 1'b1);
    chk("both_lives", lives, 2);
    chk("both_score", score, 16'h0005);
    wait_launch();
    play_event(1'b0, 1'b1);
    chk("lost_lives1", lives, 1);
    wait_launch();
    start_btn = 1'b1;
    play_event(1'b0, 1'b1);
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    pulses = 0;
    repeat (10) begin
      cycle();
      if (round_start) pulses++;
    end
    chk("over_no_launch", pulses, 0);
    chk("over_held", state_dbg, ST_OVER);
    chk("over_score_kept", score, 16'h0005);
    chk("over_level_kept", level, 1);
    start_btn = 1'b0;
    cycle();
    chk("over_released", state_dbg, ST_OVER);
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    chk("over_to_idle", state_dbg, ST_IDLE);
    cycle();
    chk("idle_stays", state_dbg, ST_IDLE);
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    chk("restart_state", state_dbg, ST_LAUNCH);
    chk("restart_pulse", round_start, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 16'h0000);
    chk("restart_level", level, 0);
    cycle();
    chk("restart_play", playing, 1);
    model_reset();

    while (m_score < 9992) begin
      play_event(1'b1, 1'b0);
      wait_launch();
    end
    chk("max_level", level, MAXL);
    play_event(1'b1, 1'b0);
    chk("sat_score", score, 16'h9999);
    wait_launch();
    repeat (WPL) begin
      play_event(1'b1, 1'b0);
      wait_launch();
    end
    chk("level_saturated", level, MAXL);
    chk("score_saturated", score, 16'h9999);

    play_event(1'b1, 1'b0);
    cycle();
    cycle();
    chk("mid_pause", state_dbg, ST_PAUSE);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_state();
    round_won = 1'b1;
    cycle();
    round_won = 1'b0;
    chk("stray_win_state", state_dbg, ST_IDLE);
    chk("stray_win_score", score, 16'h0000);
    pulses = 0;
    repeat (5) begin
      cycle();
      if (round_start) pulses++;
    end
    chk("post_reset_no_launch", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences multi-round play of the aim-and-shoot game core: issues a round-start pulse, collects won/lost results, and pauses between rounds.
- Maintains lives, level and a BCD score; exports level for the core's speed selection and score for the seven-segment display.
- Sits between key inputs and the game core; the core's own FSM runs one round per round_start pulse.

Parameters:
LIVES_INIT, 3, lives at game start (1..3)
MAX_LEVEL, 7, highest level; level saturates here
WINS_PER_LEVEL, 3, consecutive-or-not wins needed to advance one level
PAUSE_TICKS, 100, tick strobes spent in PAUSE between rounds (1..255)
SCORE_DIGITS, 4, BCD digits of score

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle game-rate strobe (100 Hz strobe_gen output)
start_btn  in  1  level-sensitive start request (key OR)
round_won  in  1  one-cycle pulse from core: target hit
round_lost  in  1  one-cycle pulse from core: projectile left screen
round_start  out  1  one-cycle pulse: core must restart its round
playing  out  1  high in PLAY
game_over  out  1  high in OVER
level  out  3  current level, 0-based
lives  out  2  remaining lives
score  out  4*SCORE_DIGITS  BCD score, digit 0 in [3:0]
state_dbg  out  3  encoded FSM state for LEDs

Behaviour:
- Reset values: state IDLE, round_start 0, playing 0, game_over 0, level 0, lives LIVES_INIT, score 0, internal win counter 0, pause counter 0.
- States (shared enum): IDLE=0, LAUNCH=1, PLAY=2, PAUSE=3, OVER=4.
- IDLE: wait for start_btn=1 (clock-rate sample, no tick needed) -> LAUNCH; lives/level/score/win counter reloaded to reset values on this transition.
- LAUNCH: lasts exactly one clock; round_start=1 for that cycle only; -> PLAY.
- PLAY: playing=1. Event evaluated every clock, independent of tick.
  - round_lost (priority if both pulses in same cycle): lives-1; if lives was 1 -> OVER (lives=0) else -> PAUSE.
  - round_won only: score += level+1 (BCD, saturates at all-9s); win counter +1; when it reaches WINS_PER_LEVEL, clear it and level+1 saturating at MAX_LEVEL (counter still clears at max); -> PAUSE.
- PAUSE: pause counter loaded with PAUSE_TICKS on entry, decremented on tick; when counter is 0 and tick=1 -> LAUNCH. Total pause = PAUSE_TICKS+1 ticks ±1 clock.
- OVER: game_over=1; score/level retained for display; start_btn rising edge (registered previous value) -> IDLE. Held button from PLAY does not restart.
- round_won/round_lost outside PLAY ignored, no state/score change.
- tick and event in same cycle: event wins, tick ignored in PLAY.
- start_btn ignored outside IDLE and OVER.
- Reset mid-round: all outputs return to reset values next clock; no round_start pulse generated.
- Score addition: one BCD digit per clock is not used; full ripple add in one cycle through sub-module, result registered; latency 1 clock from round_won to score update.
- state_dbg = state encoding.

Decomposition:
- Package game_pkg: state enum (3-bit), LIVES/LEVEL widths, default PAUSE_TICKS, BCD digit typedef (logic [3:0]).
- One sub-module: bcd_sat_adder — adds 4-bit binary increment (0..8) to SCORE_DIGITS BCD number, ripple carry, saturates to all-9s on overflow; purely combinational, instantiated once.

Test Plan:
- Reset then start_btn=1 for 1 cycle -> exactly one round_start pulse 1 clock later, playing=1, lives=3, level=0, score=0000.
- In PLAY pulse round_won -> next clock score=0001, PAUSE; after 101 ticks round_start pulses once; repeat 3 wins -> level=1, score=0003; next win -> score=0005.
- Three round_lost across rounds -> lives 2,1,0; after third, game_over=1, no round_start; start_btn held from before -> stays OVER; release and press -> IDLE; press again -> LAUNCH with lives=3, score=0.
- round_won and round_lost same cycle -> lives decremented, score unchanged.
- Preload score 9998 via repeated wins at level 7 (back-door or long run) -> win adds 8 -> score 9999 saturated; level stays 7 after further WINS_PER_LEVEL wins.
- Assert reset during PAUSE with counter at 50 -> next clock IDLE, all outputs reset values, stray round_won afterwards ignored.
